// File: rtl/net_pkg.sv
// Shared beat types for the egress merge path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package net_pkg;

    localparam int NET_DATA_W = 512;
    localparam int NET_KEEP_W = 64;

    typedef struct packed {
        logic                  last;
        logic [NET_DATA_W-1:0] data;
        logic [NET_KEEP_W-1:0] keep;
    } net_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_0,
        LOCK_1
    } arb_state_e;

    // Skid entry carries the source index alongside the beat.
    localparam int NET_SKID_W = 1 + $bits(net_beat_t);

endpackage

// File: rtl/net_pkt_arb2_if.sv
// Beat stream bundle: valid/ready handshake carrying one net_beat_t.
// Latency: n/a (wiring only).
// Backpressure: beat transfers when valid & ready on a rising clock edge.
interface net_pkt_arb2_if;
    import net_pkg::*;

    logic      valid;
    logic      ready;
    net_beat_t bits;

    modport master (output valid, output bits, input ready);
    modport slave  (input valid, input bits, output ready);

endinterface

// File: rtl/net_skid_buf.sv
// Two-entry FIFO-ordered register buffer between arbiter and output port.
// Latency: entry written in cycle t is visible on out at t+1 when empty.
// Backpressure: in_ready depends only on occupancy, never on out_ready.
module net_skid_buf #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] ent_0;
    logic [W-1:0] ent_1;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = ent_0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy and entry storage; head is always ent_0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_0 <= '0;
            ent_1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        ent_0 <= in_data;
                        cnt   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent_0 <= in_data;
                    end else if (push) begin
                        ent_1 <= in_data;
                        cnt   <= 2'd2;
                    end else if (pop) begin
                        cnt   <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent_0 <= ent_1;
                        cnt   <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/net_pkt_arb2.sv
// Packet-granular 2:1 round-robin merge of two beat streams onto one port.
// Latency: accepted beat appears on out one cycle later when the skid is empty.
// Backpressure: only the granted input sees ready, and only while the skid has room.
module net_pkt_arb2
    import net_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    net_pkt_arb2_if.slave        in_0,
    net_pkt_arb2_if.slave        in_1,
    net_pkt_arb2_if.master       out,
    output logic                 out_src,
    output logic [CNT_W-1:0]     pkt_cnt_0,
    output logic [CNT_W-1:0]     pkt_cnt_1
);

    arb_state_e            state;
    logic                  rr_last;
    logic                  sel_0;
    logic                  sel_1;
    logic                  space;
    logic                  acc_0;
    logic                  acc_1;
    logic                  push_valid;
    logic [NET_SKID_W-1:0] push_data;
    logic [NET_SKID_W-1:0] head;

    // Grant selection: ties in IDLE go to the source not served last.
    always_comb begin
        sel_0 = 1'b0;
        sel_1 = 1'b0;
        case (state)
            IDLE: begin
                sel_0 = in_0.valid & ~(in_1.valid & ~rr_last);
                sel_1 = ~sel_0 & in_1.valid;
            end
            LOCK_0:  sel_0 = 1'b1;
            LOCK_1:  sel_1 = 1'b1;
            default: ;
        endcase
    end

    assign in_0.ready = sel_0 & space & ~reset;
    assign in_1.ready = sel_1 & space & ~reset;
    assign acc_0      = in_0.valid & in_0.ready;
    assign acc_1      = in_1.valid & in_1.ready;
    assign push_valid = acc_0 | acc_1;
    assign push_data  = acc_1 ? {1'b1, in_1.bits} : {1'b0, in_0.bits};

    net_skid_buf #(
        .W (NET_SKID_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_ready  (space),
        .in_data   (push_data),
        .out_valid (out.valid),
        .out_ready (out.ready),
        .out_data  (head)
    );

    assign {out_src, out.bits} = head;

    // Packet lock FSM; the round-robin pointer moves when a packet's last beat is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr_last <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_0) begin
                        if (in_0.bits.last) rr_last <= 1'b0;
                        else                state   <= LOCK_0;
                    end else if (acc_1) begin
                        if (in_1.bits.last) rr_last <= 1'b1;
                        else                state   <= LOCK_1;
                    end
                end
                LOCK_0: begin
                    if (acc_0 && in_0.bits.last) begin
                        state   <= IDLE;
                        rr_last <= 1'b0;
                    end
                end
                LOCK_1: begin
                    if (acc_1 && in_1.bits.last) begin
                        state   <= IDLE;
                        rr_last <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-source packet counters, bumped when a last beat leaves the output port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else if (out.valid && out.ready && out.bits.last) begin
            if (out_src) pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
            else         pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
        end
    end

endmodule

// File: tb/tb_net_pkt_arb2.sv
// Self-checking bench for net_pkt_arb2: vector table plus multi-cycle sequences.
// Latency: checks one-cycle pass-through and zero-bubble source switching.
// Backpressure: toggles out ready and checks hold/stall behaviour.
module tb_net_pkt_arb2;
    import net_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        out_src;
    logic [31:0] pkt_cnt_0;
    logic [31:0] pkt_cnt_1;

    net_pkt_arb2_if in0_if ();
    net_pkt_arb2_if in1_if ();
    net_pkt_arb2_if out_if ();

    net_pkt_arb2 #(.CNT_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_0      (in0_if),
        .in_1      (in1_if),
        .out       (out_if),
        .out_src   (out_src),
        .pkt_cnt_0 (pkt_cnt_0),
        .pkt_cnt_1 (pkt_cnt_1)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic      src;
        net_beat_t beat;
    } exp_t;

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } vec_t;

    exp_t sb[$];
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   first_fire = -1;
    int   last_fire  = -1;
    int   exp_cnt0   = 0;
    int   exp_cnt1   = 0;
    logic rdy_set    = 1'b1;
    logic tog_en     = 1'b0;
    logic tog_phase  = 1'b0;
    logic stall_prev = 1'b0;
    exp_t stall_val;

    assign out_if.ready = tog_en ? tog_phase : rdy_set;

    always @(posedge clock) cyc++;

    // out ready toggles every cycle while tog_en is set
    always @(posedge clock) begin
        #1;
        if (tog_en) tog_phase = ~tog_phase;
        else        tog_phase = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic net_beat_t mk(input logic [335:0] tag, input int idx, input bit last);
        net_beat_t b;
        b.last = last;
        b.data = {tag, 176'(idx)};
        b.keep = {NET_KEEP_W{1'b1}};
        return b;
    endfunction

    // Output monitor: scoreboard pop on every transfer, hold check on every stall.
    always @(negedge clock) begin
        exp_t got;
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            got = {out_src, out_if.bits};
            if (stall_prev) begin
                n_chk++;
                if (!out_if.valid || got !== stall_val) begin
                    n_fail++;
                    $display("FAIL hold: out changed while stalled, valid=%0d src=%0d data=%h",
                             out_if.valid, out_src, out_if.bits.data);
                end
            end
            if (out_if.valid && out_if.ready) begin
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected src=%0d data=%h", out_src, out_if.bits.data);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL beat: got src=%0d last=%0d data=%h keep=%h, expected src=%0d last=%0d data=%h keep=%h",
                                 got.src, got.beat.last, got.beat.data, got.beat.keep,
                                 e.src, e.beat.last, e.beat.data, e.beat.keep);
                    end
                end
            end
            stall_prev = out_if.valid && !out_if.ready;
            stall_val  = got;
        end
    end

    task automatic push_exp(input bit src, input int n, input logic [335:0] tag);
        for (int i = 0; i < n; i++) sb.push_back({src, mk(tag, i, i == n - 1)});
        if (src) exp_cnt1++;
        else     exp_cnt0++;
    endtask

    // Drives one packet on a source, holding valid until each beat is taken.
    task automatic send_pkt(input bit src, input int n, input logic [335:0] tag);
        int   wait_c;
        bit   done;
        logic rdy;
        for (int i = 0; i < n; i++) begin
            if (src) begin
                in1_if.valid = 1'b1;
                in1_if.bits  = mk(tag, i, i == n - 1);
            end else begin
                in0_if.valid = 1'b1;
                in0_if.bits  = mk(tag, i, i == n - 1);
            end
            wait_c = 0;
            done   = 0;
            while (!done) begin
                @(negedge clock);
                rdy = src ? in1_if.ready : in0_if.ready;
                @(posedge clock);
                #1;
                wait_c++;
                if (rdy) begin
                    done = 1;
                end else if (wait_c > 200) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL accept_timeout: src=%0d beat=%0d not taken in 200 cycles", src, i);
                    done = 1;
                end
            end
        end
        if (src) in1_if.valid = 1'b0;
        else     in0_if.valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clock);
            k++;
        end
        @(negedge clock);
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        exp_cnt0   = 0;
        exp_cnt1   = 0;
        first_fire = -1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        bit   s_done;
        bit   saw_stall;
        exp_t e;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

        in0_if.valid = 1'b0;
        in1_if.valid = 1'b0;
        in0_if.bits  = '0;
        in1_if.bits  = '0;

        // Reset held 1000 ns with a source pushing: nothing may leak out.
        in0_if.valid = 1'b1;
        in0_if.bits  = mk(336'h7, 0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("rst_out_valid", 64'(out_if.valid), 64'd0);
            check("rst_in0_ready", 64'(in0_if.ready), 64'd0);
            check("rst_in1_ready", 64'(in1_if.ready), 64'd0);
            check("rst_cnt0", 64'(pkt_cnt_0), 64'd0);
            check("rst_cnt1", 64'(pkt_cnt_1), 64'd0);
        end
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_data", 64'(out_if.bits.data[511:448]), 64'd0);
        in0_if.valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Vector table of single-beat packets: round-robin tie breaking.
        for (int r = 0; r < 9; r++) begin
            in0_if.valid = vecs[r].v0;
            in1_if.valid = vecs[r].v1;
            in0_if.bits  = mk(336'h100 + 336'(r), 0, 1'b1);
            in1_if.bits  = mk(336'h200 + 336'(r), 0, 1'b1);
            in1_if.bits.keep = '0;
            @(negedge clock);
            check($sformatf("vec%0d_ready0", r), 64'(in0_if.ready), 64'(vecs[r].r0));
            check($sformatf("vec%0d_ready1", r), 64'(in1_if.ready), 64'(vecs[r].r1));
            if (vecs[r].r0) begin
                sb.push_back({1'b0, in0_if.bits});
                exp_cnt0++;
            end
            if (vecs[r].r1) begin
                sb.push_back({1'b1, in1_if.bits});
                exp_cnt1++;
            end
            @(posedge clock);
            #1;
        end
        in0_if.valid = 1'b0;
        in1_if.valid = 1'b0;
        drain("vec_drain");
        check("vec_cnt0", 64'(pkt_cnt_0), 64'(exp_cnt0));
        check("vec_cnt1", 64'(pkt_cnt_1), 64'(exp_cnt1));

        // Single beat pass-through with one cycle latency.
        do_reset();
        e = {1'b0, mk(336'h5, 0, 1'b1)};
        sb.push_back(e);
        in0_if.valid = 1'b1;
        in0_if.bits  = e.beat;
        @(negedge clock);
        check("single_ready0", 64'(in0_if.ready), 64'd1);
        @(posedge clock);
        #1;
        in0_if.valid = 1'b0;
        @(negedge clock);
        check("single_latency_valid", 64'(out_if.valid), 64'd1);
        check("single_out_src", 64'(out_src), 64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("single_cnt0", 64'(pkt_cnt_0), 64'd1);
        drain("single_drain");

        // Both sources with 3-beat packets: whole packets, no bubble between them.
        do_reset();
        push_exp(1'b0, 3, 336'h2);
        push_exp(1'b1, 3, 336'h3);
        fork
            send_pkt(1'b0, 3, 336'h2);
            send_pkt(1'b1, 3, 336'h3);
        join
        drain("both_drain");
        check("both_no_bubble", 64'(last_fire - first_fire), 64'd5);
        check("both_cnt0", 64'(pkt_cnt_0), 64'd1);
        check("both_cnt1", 64'(pkt_cnt_1), 64'd1);

        // Source 0 arrives while source 1 is mid-packet: locked out until last beat.
        do_reset();
        push_exp(1'b1, 3, 336'h41);
        push_exp(1'b0, 2, 336'h40);
        s_done = 0;
        fork
            begin
                send_pkt(1'b1, 3, 336'h41);
                s_done = 1;
            end
            begin
                @(posedge clock);
                #1;
                @(posedge clock);
                #1;
                send_pkt(1'b0, 2, 336'h40);
            end
            begin
                while (!s_done) begin
                    @(negedge clock);
                    if (!s_done && in0_if.valid) check("lock_ready0", 64'(in0_if.ready), 64'd0);
                end
            end
        join
        drain("lock_drain");
        check("lock_cnt0", 64'(pkt_cnt_0), 64'd1);
        check("lock_cnt1", 64'(pkt_cnt_1), 64'd1);

        // out ready toggling over a 4-beat packet: skid fills, input stalls, order kept.
        do_reset();
        tog_en = 1'b1;
        push_exp(1'b0, 4, 336'h50);
        s_done    = 0;
        saw_stall = 0;
        fork
            begin
                send_pkt(1'b0, 4, 336'h50);
                s_done = 1;
            end
            begin
                while (!s_done) begin
                    @(negedge clock);
                    if (in0_if.valid && !in0_if.ready) saw_stall = 1;
                end
            end
        join
        drain("toggle_drain");
        tog_en = 1'b0;
        check("toggle_saw_stall", 64'(saw_stall), 64'd1);
        check("toggle_cnt0", 64'(pkt_cnt_0), 64'd1);

        // Reset mid-packet: skid content dropped, counters cleared, clean restart.
        rdy_set = 1'b0;
        in0_if.valid = 1'b1;
        in0_if.bits  = mk(336'h60, 0, 1'b0);
        @(posedge clock);
        #1;
        in0_if.bits  = mk(336'h60, 1, 1'b0);
        @(posedge clock);
        #1;
        in0_if.valid = 1'b0;
        @(negedge clock);
        check("midrst_pre_valid", 64'(out_if.valid), 64'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_if.valid), 64'd0);
        check("midrst_cnt0", 64'(pkt_cnt_0), 64'd0);
        check("midrst_cnt1", 64'(pkt_cnt_1), 64'd0);
        sb.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        rdy_set = 1'b1;
        @(posedge clock);
        #1;
        push_exp(1'b0, 4, 336'h61);
        send_pkt(1'b0, 4, 336'h61);
        drain("midrst_drain");
        check("midrst_after_cnt0", 64'(pkt_cnt_0), 64'd1);
        check("midrst_after_cnt1", 64'(pkt_cnt_1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
